// File: rtl/arm_fetch_pkg.sv
// arm_fetch_pkg
//   Shared definitions for the instruction fetch stage: the fetch FSM state
//   type, instruction width, PC increment and the NOP word that is loaded
//   when a fetch times out.
//   Optional feature macro used by the fetch files: FETCH_TIMEOUT_EN.
package arm_fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_t;

    localparam int unsigned INST_W  = 32;
    localparam int unsigned PC_STEP = 4;

    // MOV r0,r0
    localparam logic [INST_W-1:0] NOP_INST = 32'hE1A00000;

endpackage

// File: rtl/instruction_fetch_unit_timeout.sv
// fetch_timeout_counter
//   Counts consecutive enabled cycles and raises hit on the TIMEOUT-th one.
//   Only instantiated by instruction_fetch_unit when FETCH_TIMEOUT_EN is defined.
// Ports
//   clk     in  clock, rising edge
//   clear   in  synchronous clear (reset, branch, memory completion)
//   enable  in  count this cycle (fetch outstanding)
//   hit     out combinational: this enabled cycle is the TIMEOUT-th one
module fetch_timeout_counter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic clear,
    input  logic enable,
    output logic hit
);

    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] count;

    // count holds the number of enabled cycles already seen, so the
    // TIMEOUT-th cycle is the one where count equals TIMEOUT-1.
    assign hit = enable && (count == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (clear || hit) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
//   Fetch stage feeding the instruction encoder. Holds the PC, runs the
//   mem_rd/mem_moc read handshake, and latches the returned word into the
//   instruction register, held with ir_valid until ir_ack. pc_load redirects
//   the PC and flushes any in-flight fetch or unconsumed instruction.
//   Optional feature: FETCH_TIMEOUT_EN adds a fetch timeout that loads a NOP
//   and pulses fetch_err; without it fetch_err stays 0.
// Ports
//   clk       in   clock, rising edge
//   reset     in   synchronous active-high reset
//   mem_addr  out  read address (= pc)
//   mem_rd    out  read request, held until mem_moc
//   mem_moc   in   memory operation complete, mem_data valid
//   mem_data  in   instruction word from memory
//   ir_out    out  instruction register
//   ir_valid  out  ir_out holds an unconsumed instruction
//   ir_ack    in   control unit consumed ir_out
//   pc_load   in   branch: load pc_in (word aligned), flush
//   pc_in     in   branch target
//   pc_out    out  current PC
//   fetch_err out  one-cycle pulse on fetch timeout
module instruction_fetch_unit
    import arm_fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int unsigned        TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic              mem_moc,
    input  logic [INST_W-1:0] mem_data,
    output logic [INST_W-1:0] ir_out,
    output logic              ir_valid,
    input  logic              ir_ack,
    input  logic              pc_load,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [ADDR_W-1:0] pc_out,
    output logic              fetch_err
);

    fetch_state_t      state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [INST_W-1:0] ir_n;
    logic              ir_valid_n;
    logic              mem_rd_n;
    logic              fetch_err_n;
    logic [ADDR_W-1:0] pc_inc;

    assign pc_inc   = pc + ADDR_W'(PC_STEP);
    assign mem_addr = pc;
    assign pc_out   = pc;

`ifdef FETCH_TIMEOUT_EN
    logic to_clear;
    logic to_hit;

    assign to_clear = reset || pc_load || ((state == S_FETCH) && mem_moc);

    fetch_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .clear  (to_clear),
        .enable (state == S_FETCH),
        .hit    (to_hit)
    );
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            ir_out    <= '0;
            ir_valid  <= 1'b0;
            mem_rd    <= 1'b0;
            fetch_err <= 1'b0;
        end else begin
            state     <= state_n;
            pc        <= pc_n;
            ir_out    <= ir_n;
            ir_valid  <= ir_valid_n;
            mem_rd    <= mem_rd_n;
            fetch_err <= fetch_err_n;
        end
    end

    // mem_rd is the registered copy of "still waiting in S_FETCH", so it
    // rises one cycle after S_FETCH is entered and drops on the completion edge.
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        ir_n        = ir_out;
        ir_valid_n  = ir_valid;
        mem_rd_n    = mem_rd;
        fetch_err_n = 1'b0;

        if (pc_load) begin
            state_n    = S_FETCH;
            pc_n       = {pc_in[ADDR_W-1:2], 2'b00};
            ir_valid_n = 1'b0;
            mem_rd_n   = 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    state_n  = S_FETCH;
                    mem_rd_n = 1'b0;
                end
                S_FETCH: begin
                    if (mem_moc) begin
                        ir_n       = mem_data;
                        ir_valid_n = 1'b1;
                        pc_n       = pc_inc;
                        state_n    = S_HOLD;
                        mem_rd_n   = 1'b0;
                    end
`ifdef FETCH_TIMEOUT_EN
                    else if (to_hit) begin
                        ir_n        = NOP_INST;
                        ir_valid_n  = 1'b1;
                        pc_n        = pc_inc;
                        state_n     = S_HOLD;
                        mem_rd_n    = 1'b0;
                        fetch_err_n = 1'b1;
                    end
`endif
                    else begin
                        mem_rd_n = 1'b1;
                    end
                end
                S_HOLD: begin
                    mem_rd_n = 1'b0;
                    if (ir_ack) begin
                        ir_valid_n = 1'b0;
                        state_n    = S_FETCH;
                    end
                end
                default: begin
                    state_n  = S_IDLE;
                    mem_rd_n = 1'b0;
                end
            endcase
        end
    end

endmodule
